// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and width helpers for the async-FIFO write-side arbiter.
// Holds the arbiter state encoding and the grant-index / beat-counter width functions.
// Imported by fifo_wr_arbiter and its round-robin finder.
package fifo_wr_arbiter_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      BURST = 1'b1
   } arb_state_e;

   // Width of a requester index (grant_id, rr_ptr).
   function automatic int gnt_w(input int nreq);
      return (nreq <= 2) ? 1 : $clog2(nreq);
   endfunction

   // Width of the per-grant beat counter; must be able to hold MAX_BURST.
   function automatic int cnt_w(input int max_burst);
      return (max_burst <= 1) ? 1 : $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Round-robin priority finder: first set bit of req_i at or above rr_ptr_i, wrapping.
// Latency: purely combinational.
// Backpressure: none; any_o reports whether any request is present.
// Ports: req_i (request vector), rr_ptr_i (search start), winner_o (index), any_o.
module fifo_wr_arbiter_rr_pick
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NREQ = 4
) (
   input  logic [NREQ-1:0]        req_i,
   input  logic [gnt_w(NREQ)-1:0] rr_ptr_i,
   output logic [gnt_w(NREQ)-1:0] winner_o,
   output logic                   any_o
);

   localparam int GNT_W = gnt_w(NREQ);

   logic             found;
   logic [GNT_W-1:0] idx;

   always_comb begin
      winner_o = '0;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < NREQ; i++) begin
         // Modulo NREQ keeps the wrap correct for non-power-of-2 requester counts.
         idx = GNT_W'((int'(rr_ptr_i) + i) % NREQ);
         if (!found && req_i[idx]) begin
            found    = 1'b1;
            winner_o = idx;
         end
      end
      any_o = |req_i;
   end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locked arbiter sharing one async-FIFO write port among NREQ requesters.
// Latency: 1 cycle IDLE->grant; beats pass combinationally to fifo_winc/fifo_wdata.
// Backpressure: wfull stalls the granted requester; almost_full only blocks new grants.
// Ports: wclk/wrst_n; req_valid/req_data/req_last/req_ready per requester;
//        fifo_winc/fifo_wdata/fifo_wfull/fifo_almost_full to the FIFO;
//        grant_active/grant_id/beat_count status.
module fifo_wr_arbiter
   import fifo_wr_arbiter_pkg::*;
#(
   parameter int NREQ      = 4,
   parameter int DSIZE     = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                         wclk,
   input  logic                         wrst_n,
   input  logic [NREQ-1:0]              req_valid,
   input  logic [NREQ*DSIZE-1:0]        req_data,
   input  logic [NREQ-1:0]              req_last,
   output logic [NREQ-1:0]              req_ready,
   output logic                         fifo_winc,
   output logic [DSIZE-1:0]             fifo_wdata,
   input  logic                         fifo_wfull,
   input  logic                         fifo_almost_full,
   output logic                         grant_active,
   output logic [gnt_w(NREQ)-1:0]       grant_id,
   output logic [cnt_w(MAX_BURST)-1:0]  beat_count
);

   localparam int GNT_W = gnt_w(NREQ);
   localparam int CNT_W = cnt_w(MAX_BURST);

   arb_state_e       state_q, state_d;
   logic [GNT_W-1:0] gnt_q, gnt_d;
   logic [GNT_W-1:0] rr_q, rr_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [GNT_W-1:0] pick_win;
   logic             pick_any;
   logic             sel_valid;
   logic             sel_last;

   fifo_wr_arbiter_rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req_i    (req_valid),
      .rr_ptr_i (rr_q),
      .winner_o (pick_win),
      .any_o    (pick_any)
   );

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      rr_d       = rr_q;
      cnt_d      = cnt_q;
      req_ready  = '0;
      fifo_winc  = 1'b0;
      fifo_wdata = '0;
      sel_valid  = 1'b0;
      sel_last   = 1'b0;

      case (state_q)
         IDLE: begin
            // Grant is registered; no beat moves in the arbitration cycle.
            if (pick_any && !fifo_almost_full) begin
               state_d = BURST;
               gnt_d   = pick_win;
               cnt_d   = '0;
            end
         end

         BURST: begin
            // Constant-index loop acts as the grant_id mux for ready, data, valid, last.
            for (int i = 0; i < NREQ; i++) begin
               if (gnt_q == GNT_W'(i)) begin
                  req_ready[i] = !fifo_wfull;
                  fifo_wdata   = req_data[i*DSIZE +: DSIZE];
                  sel_valid    = req_valid[i];
                  sel_last     = req_last[i];
               end
            end
            fifo_winc = sel_valid && !fifo_wfull;

            // Valid gaps and wfull simply hold the grant; only a moved beat advances it.
            if (fifo_winc) begin
               cnt_d = cnt_q + 1'b1;
               if (sel_last || (cnt_q == CNT_W'(MAX_BURST - 1))) begin
                  state_d = IDLE;
                  rr_d    = (gnt_q == GNT_W'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q <= IDLE;
         gnt_q   <= '0;
         rr_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         gnt_q   <= gnt_d;
         rr_q    <= rr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign grant_active = (state_q == BURST);
   assign grant_id     = gnt_q;
   assign beat_count   = cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
module tb_fifo_wr_arbiter;

   localparam int NREQ      = 4;
   localparam int DSIZE     = 8;
   localparam int MAX_BURST = 4;

   logic                  wclk = 1'b0;
   logic                  wrst_n = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*DSIZE-1:0] req_data = '0;
   logic [NREQ-1:0]       req_last = '0;
   logic [NREQ-1:0]       req_ready;
   logic                  fifo_winc;
   logic [DSIZE-1:0]      fifo_wdata;
   logic                  fifo_wfull = 1'b0;
   logic                  fifo_almost_full = 1'b0;
   logic                  grant_active;
   logic [1:0]            grant_id;
   logic [2:0]            beat_count;

   always #5 wclk = ~wclk;

   fifo_wr_arbiter #(
      .NREQ      (NREQ),
      .DSIZE     (DSIZE),
      .MAX_BURST (MAX_BURST)
   ) dut (
      .wclk             (wclk),
      .wrst_n           (wrst_n),
      .req_valid        (req_valid),
      .req_data         (req_data),
      .req_last         (req_last),
      .req_ready        (req_ready),
      .fifo_winc        (fifo_winc),
      .fifo_wdata       (fifo_wdata),
      .fifo_wfull       (fifo_wfull),
      .fifo_almost_full (fifo_almost_full),
      .grant_active     (grant_active),
      .grant_id         (grant_id),
      .beat_count       (beat_count)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        rst_n;
      logic [3:0]  valid;
      logic [3:0]  last;
      logic [31:0] data;
      logic        wfull;
      logic        af;
      logic [3:0]  e_ready;
      logic        e_winc;
      logic [7:0]  e_wdata;
      logic        e_act;
      logic [1:0]  e_gid;
      logic [2:0]  e_cnt;
   } vec_t;

   vec_t vt[$];

   function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] l, logic [31:0] d,
                               logic wf, logic af, logic [3:0] er, logic ew,
                               logic [7:0] ed, logic ea, logic [1:0] eg, logic [2:0] ec);
      vec_t x;
      x.rst_n = r;  x.valid = v;  x.last = l;  x.data = d;  x.wfull = wf;  x.af = af;
      x.e_ready = er; x.e_winc = ew; x.e_wdata = ed; x.e_act = ea; x.e_gid = eg; x.e_cnt = ec;
      return x;
   endfunction

   // ---------------- reference model + stimulus state ----------------
   bit m_busy;
   int m_gid, m_rr, m_cnt;
   int pend[NREQ];
   int seq[NREQ];
   int pq[NREQ][$];
   int blog_id[$], blog_len[$], blog_gap[$];
   int obs_len, obs_gap, obs_gid, obs_total;
   bit prev_act;

   task automatic reset_all();
      @(negedge wclk);
      wrst_n = 1'b0;
      req_valid = '0; req_last = '0; req_data = '0;
      fifo_wfull = 1'b0; fifo_almost_full = 1'b0;
      m_busy = 1'b0; m_gid = 0; m_rr = 0; m_cnt = 0;
      for (int i = 0; i < NREQ; i++) begin
         pend[i] = 0; seq[i] = 0; pq[i].delete();
      end
      blog_id.delete(); blog_len.delete(); blog_gap.delete();
      obs_len = 0; obs_gap = 0; obs_gid = 0; obs_total = 0; prev_act = 1'b0;
      @(negedge wclk);
      #2;
      chk("rst_active", 32'(grant_active), 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      wrst_n = 1'b1;
   endtask

   // Drives requester packets for ncyc cycles and compares every output with the model.
   task automatic run(input int ncyc, input int gap_pct, input int full_pct, input int af_pct);
      logic [3:0]  v, l, e_ready;
      logic [31:0] dat;
      logic        wf, af, e_winc;
      logic [7:0]  e_wdata;
      for (int c = 0; c < ncyc; c++) begin
         @(negedge wclk);
         v = '0; l = '0; dat = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (pend[i] == 0 && pq[i].size() > 0) pend[i] = pq[i].pop_front();
            if (pend[i] > 0 && int'($urandom_range(99)) >= gap_pct) v[i] = 1'b1;
            l[i] = (pend[i] == 1);
            dat[i*8 +: 8] = 8'(i * 64 + (seq[i] % 64));
         end
         wf = (int'($urandom_range(99)) < full_pct);
         af = (int'($urandom_range(99)) < af_pct);
         req_valid = v; req_last = l; req_data = dat;
         fifo_wfull = wf; fifo_almost_full = af;
         #2;
         e_ready = (m_busy && !wf) ? 4'(1 << m_gid) : 4'b0;
         e_winc  = m_busy && v[m_gid] && !wf;
         e_wdata = m_busy ? dat[m_gid*8 +: 8] : 8'h00;
         chk("run_ready", 32'(req_ready), 32'(e_ready));
         chk("run_winc", 32'(fifo_winc), 32'(e_winc));
         chk("run_wdata", 32'(fifo_wdata), 32'(e_wdata));
         chk("run_active", 32'(grant_active), 32'(m_busy));
         chk("run_gid", 32'(grant_id), 32'(m_gid));
         chk("run_cnt", 32'(beat_count), 32'(m_cnt));
         // Burst log built from what the DUT actually did.
         if (grant_active && !prev_act) begin
            blog_gap.push_back(obs_gap); obs_len = 0; obs_gid = int'(grant_id);
         end
         if (grant_active && fifo_winc) begin
            obs_len++; obs_total++;
         end
         if (!grant_active && prev_act) begin
            blog_id.push_back(obs_gid); blog_len.push_back(obs_len); obs_gap = 0;
         end
         if (!grant_active) obs_gap++;
         prev_act = grant_active;
         // Model advance for the coming clock edge.
         if (!m_busy) begin
            if (v != 0 && !af) begin
               for (int k = NREQ - 1; k >= 0; k--)
                  if (v[(m_rr + k) % NREQ]) m_gid = (m_rr + k) % NREQ;
               m_busy = 1'b1;
               m_cnt  = 0;
            end
         end else if (e_winc) begin
            seq[m_gid]++;
            pend[m_gid]--;
            m_cnt++;
            if (l[m_gid] || m_cnt == MAX_BURST) begin
               m_busy = 1'b0;
               m_rr   = (m_gid + 1) % NREQ;
            end
         end
      end
   endtask

   task automatic check_bursts(input string nm, input int ids[5], input int lens[5]);
      chk({nm, "_nbursts_ge5"}, 32'(blog_id.size() >= 5), 32'd1);
      for (int k = 0; k < 5; k++) begin
         if (k < blog_id.size()) begin
            chk({nm, "_id"}, 32'(blog_id[k]), 32'(ids[k]));
            chk({nm, "_len"}, 32'(blog_len[k]), 32'(lens[k]));
            chk({nm, "_gap"}, 32'(blog_gap[k]), 32'd1);
         end
      end
   endtask

   initial begin
      int ids[5];
      int lens[5];
      int total_gen;
      int left;

      // Columns: rst valid last data wfull af | ready winc wdata active gid cnt
      vt.push_back(mk(0, 4'b1111, 4'b0000, 32'h11223344, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
      // single 3-beat packet from requester 2
      vt.push_back(mk(1, 4'b0100, 4'b0000, 32'h00A10000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
      vt.push_back(mk(1, 4'b0100, 4'b0000, 32'h00A10000, 0, 0, 4'b0100, 1, 8'hA1, 1, 2, 0));
      vt.push_back(mk(1, 4'b0100, 4'b0000, 32'h00B20000, 0, 0, 4'b0100, 1, 8'hB2, 1, 2, 1));
      vt.push_back(mk(1, 4'b0100, 4'b0100, 32'h00C30000, 0, 0, 4'b0100, 1, 8'hC3, 1, 2, 2));
      vt.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 8'h00, 0, 2, 3));
      // all valid: pointer now 3 so requester 3 wins
      vt.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 4'b0000, 0, 8'h00, 0, 2, 3));
      vt.push_back(mk(1, 4'b1111, 4'b1111, 32'h13121110, 0, 0, 4'b1000, 1, 8'h13, 1, 3, 0));
      vt.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 8'h00, 0, 3, 1));
      // wfull stalls beats 2-4 of a requester-0 burst
      vt.push_back(mk(1, 4'b0001, 4'b0000, 32'h00000040, 0, 0, 4'b0000, 0, 8'h00, 0, 3, 1));
      vt.push_back(mk(1, 4'b0001, 4'b0000, 32'h00000040, 0, 0, 4'b0001, 1, 8'h40, 1, 0, 0));
      for (int k = 0; k < 3; k++)
         vt.push_back(mk(1, 4'b0001, 4'b0000, 32'h00000041, 1, 0, 4'b0000, 0, 8'h41, 1, 0, 1));
      vt.push_back(mk(1, 4'b0001, 4'b0000, 32'h00000041, 0, 0, 4'b0001, 1, 8'h41, 1, 0, 1));
      vt.push_back(mk(1, 4'b0001, 4'b0001, 32'h00000042, 0, 0, 4'b0001, 1, 8'h42, 1, 0, 2));
      vt.push_back(mk(1, 4'b0000, 4'b0000, 32'h00000000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 3));
      // almost_full blocks grants, but not a running burst
      vt.push_back(mk(1, 4'b0011, 4'b0000, 32'h00005150, 0, 1, 4'b0000, 0, 8'h00, 0, 0, 3));
      vt.push_back(mk(1, 4'b0011, 4'b0000, 32'h00005150, 0, 1, 4'b0000, 0, 8'h00, 0, 0, 3));
      vt.push_back(mk(1, 4'b0011, 4'b0000, 32'h00005150, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 3));
      vt.push_back(mk(1, 4'b0011, 4'b0000, 32'h00005150, 0, 1, 4'b0010, 1, 8'h51, 1, 1, 0));
      vt.push_back(mk(1, 4'b0011, 4'b0010, 32'h00005250, 0, 1, 4'b0010, 1, 8'h52, 1, 1, 1));
      vt.push_back(mk(1, 4'b0011, 4'b0000, 32'h00005250, 0, 1, 4'b0000, 0, 8'h00, 0, 1, 2));
      // reset on beat 2 of a requester-3 burst, then restart from pointer 0
      vt.push_back(mk(1, 4'b1000, 4'b0000, 32'h60000000, 0, 0, 4'b0000, 0, 8'h00, 0, 1, 2));
      vt.push_back(mk(1, 4'b1000, 4'b0000, 32'h60000000, 0, 0, 4'b1000, 1, 8'h60, 1, 3, 0));
      vt.push_back(mk(0, 4'b1000, 4'b0000, 32'h61000000, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 4'b0000, 32'h73727170, 0, 0, 4'b0000, 0, 8'h00, 0, 0, 0));
      vt.push_back(mk(1, 4'b1111, 4'b0000, 32'h73727170, 0, 0, 4'b0001, 1, 8'h70, 1, 0, 0));

      for (int n = 0; n < vt.size(); n++) begin
         @(negedge wclk);
         wrst_n = vt[n].rst_n;
         req_valid = vt[n].valid; req_last = vt[n].last; req_data = vt[n].data;
         fifo_wfull = vt[n].wfull; fifo_almost_full = vt[n].af;
         #2;
         chk($sformatf("vec%0d_ready", n), 32'(req_ready), 32'(vt[n].e_ready));
         chk($sformatf("vec%0d_winc", n), 32'(fifo_winc), 32'(vt[n].e_winc));
         chk($sformatf("vec%0d_wdata", n), 32'(fifo_wdata), 32'(vt[n].e_wdata));
         chk($sformatf("vec%0d_active", n), 32'(grant_active), 32'(vt[n].e_act));
         chk($sformatf("vec%0d_gid", n), 32'(grant_id), 32'(vt[n].e_gid));
         chk($sformatf("vec%0d_cnt", n), 32'(beat_count), 32'(vt[n].e_cnt));
      end

      // Four requesters continuously valid with 2-beat packets.
      reset_all();
      for (int i = 0; i < NREQ; i++) begin
         pq[i].push_back(2); pq[i].push_back(2);
      end
      run(20, 0, 0, 0);
      ids  = '{0, 1, 2, 3, 0};
      lens = '{2, 2, 2, 2, 2};
      check_bursts("rr4", ids, lens);

      // 10-beat packet split by the burst cap, interleaved with requester 3.
      reset_all();
      pq[1].push_back(10);
      pq[3].push_back(1); pq[3].push_back(1); pq[3].push_back(1);
      run(24, 0, 0, 0);
      ids  = '{1, 3, 1, 3, 1};
      lens = '{4, 1, 4, 1, 2};
      check_bursts("split", ids, lens);

      // Randomized traffic with valid gaps, wfull and almost_full, then a clean drain.
      reset_all();
      total_gen = 0;
      for (int i = 0; i < NREQ; i++)
         for (int p = 0; p < 6; p++) begin
            pq[i].push_back(int'($urandom_range(1, 6)));
            total_gen += pq[i][p];
         end
      run(600, 25, 20, 15);
      run(300, 0, 0, 0);
      left = 0;
      for (int i = 0; i < NREQ; i++) left += pend[i] + pq[i].size();
      chk("rand_drained", 32'(left), 32'd0);
      chk("rand_total_beats", 32'(obs_total), 32'(total_gen));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
Write-side arbiter that shares the single write port of the async FIFO among NREQ requesters in the wclk domain.
Grants are round-robin and burst-locked: a grant holds until the requester's last beat or until MAX_BURST beats, whichever comes first.
Beats pass combinationally to the FIFO write port and are throttled by the FIFO's wfull and almost_full flags.
The block sits directly in front of the FIFO's winc/wdata inputs.

Parameters:
NREQ, 4, number of requesters (2..16)
DSIZE, 8, data width; must equal the FIFO DSIZE
MAX_BURST, 4, maximum beats per grant (>=1); fairness cap

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  reset; asynchronous, active-low
req_valid  in  NREQ  per-requester beat valid
req_data  in  NREQ*DSIZE  packed beat data; requester i occupies bits [i*DSIZE +: DSIZE]
req_last  in  NREQ  marks the final beat of a requester's packet
req_ready  out  NREQ  per-requester beat accept
fifo_winc  out  1  FIFO write enable
fifo_wdata  out  DSIZE  FIFO write data
fifo_wfull  in  1  FIFO full flag
fifo_almost_full  in  1  FIFO almost-full flag (threshold set at the FIFO)
grant_active  out  1  a burst grant is held
grant_id  out  clog2(NREQ)  index of the granted requester
beat_count  out  clog2(MAX_BURST+1)  beats accepted in the current grant

Behaviour:
- Reset values: state=IDLE, grant_active=0, grant_id=0, rr_ptr=0, beat_count=0, req_ready=0, fifo_winc=0.
- States:
  - IDLE: no grant held.
  - BURST: grant held by grant_id.
- IDLE -> BURST:
  - Requires |req_valid && !fifo_almost_full.
  - Winner is the first valid index searching upward from rr_ptr, with wrap-around.
  - grant_id, grant_active and beat_count<=0 are registered, so there is a 1-cycle arbitration latency.
  - No beat is accepted in IDLE.
- BURST handshake (all combinational from registered grant state):
  - req_ready[grant_id] = !fifo_wfull; all other req_ready bits are 0.
  - fifo_winc = req_valid[grant_id] && !fifo_wfull.
  - fifo_wdata = req_data slice of grant_id, driven every cycle in BURST; 0 in IDLE.
  - A beat transfers when fifo_winc=1; beat_count increments.
- BURST -> IDLE:
  - Occurs on a transferring beat with req_last[grant_id]=1, or with beat_count==MAX_BURST-1.
  - On exit, rr_ptr <= grant_id+1 modulo NREQ.
  - One mandatory idle cycle separates consecutive bursts.
- Valid gaps:
  - If req_valid[grant_id] drops mid-burst, the grant is held (packet lock) with no timeout.
  - Requesters must not abandon a packet mid-burst.
- Flow-control flags:
  - fifo_almost_full only blocks new grants; an in-progress burst continues.
  - fifo_wfull stalls the current burst with no state change.
  - The block never asserts fifo_winc while fifo_wfull=1, so FIFO overflow_error is unreachable.
- MAX_BURST=1: every grant is a single beat and req_last is ignored for exit.
- Forced release at MAX_BURST splits the packet. The same requester re-arbitrates and resumes later; data order per requester is preserved.
- Simultaneous IDLE arrivals: round-robin order only; there is no fixed priority beyond rr_ptr.
- Reset mid-burst: state is cleared immediately and the partial packet remains in the FIFO. Framing recovery is the consumer's responsibility.
- Width rules:
  - beat_count saturates logically at MAX_BURST; it never exceeds MAX_BURST-1 while in BURST.
  - rr_ptr wraps modulo NREQ, so non-power-of-2 NREQ is supported.

Decomposition:
- Shared package holds:
  - the state encoding typedef (IDLE, BURST);
  - the width helpers GNT_W=clog2(NREQ) and CNT_W=clog2(MAX_BURST+1).
- One sub-module: rr_pick, a combinational round-robin priority finder.
  - Inputs: req vector, rr_ptr. Outputs: winner index, any.
  - Unit-testable on its own.
- FSM, beat counter and muxes live in fifo_wr_arbiter.

Test Plan:
1. Reset, then req_valid=4'b0100 with a 3-beat packet (last on beat 3) -> grant_id=2 one cycle later; fifo_winc high 3 consecutive cycles with data A,B,C; IDLE; rr_ptr=3.
2. All 4 requesters continuously valid with 2-beat packets, MAX_BURST=4 -> grant order 0,1,2,3,0; exactly 2 beats each; one idle cycle between bursts.
3. Requester 1 sends a 10-beat packet, MAX_BURST=4, requester 3 also valid -> bursts of 4 (req1), then req3, then 4 (req1), then req3, then 2 (req1); req1 data order intact.
4. fifo_wfull=1 for cycles 2-4 of a burst -> req_ready and fifo_winc low for 3 cycles; beat_count frozen; burst completes after wfull clears with no lost or duplicated beat.
5. fifo_almost_full=1 with req_valid=4'b0011 in IDLE -> no grant while asserted. With almost_full rising mid-burst -> burst completes.
6. Assert wrst_n=0 on beat 2 of a burst -> same-cycle clear: grant_active=0, req_ready=0, fifo_winc=0. After release, arbitration restarts from rr_ptr=0.
